// File: rtl/enc_controller.sv
// enc_controller: Reed-Solomon encoder beat controller.
//
// Tracks the codeword position of each output beat, tells the formatter how
// many message symbols to pop, and manages the symbol buffer fill level.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   con_enable          start / continue encoding, sampled at codeword boundaries
//   con_abort           synchronous clear to idle
//   in_valid, in_ready  upstream beat of ENC_SYM_NUM message symbols
//   out_valid, out_ready formatter output beat handshake
//   con_master_counter  codeword index of the first symbol of the current beat
//   buf_request         message symbols popped by the formatter this beat
//   con_buf_level       buffered symbol count
//   con_parity          current beat carries parity symbols
//   con_last            current beat is the final beat of the codeword
module enc_controller #(
    parameter int ENC_SYM_NUM = 8,
    parameter int RS_MES_LEN  = 239,
    parameter int RS_COD_LEN  = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             con_enable,
    input  logic                             con_abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(RS_COD_LEN)-1:0]    con_master_counter,
    output logic [$clog2(ENC_SYM_NUM+1)-1:0] buf_request,
    output logic [$clog2(2*ENC_SYM_NUM)-1:0] con_buf_level,
    output logic                             con_parity,
    output logic                             con_last
);
    localparam int CW = $clog2(RS_COD_LEN);
    localparam int RW = $clog2(ENC_SYM_NUM + 1);
    localparam int LW = $clog2(2 * ENC_SYM_NUM);
    localparam int N  = ENC_SYM_NUM;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MSG  = 2'd1;
    localparam logic [1:0] PAR  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          alive;
    logic [31:0]   c_ext;
    logic [31:0]   c_end;
    logic [31:0]   lvl_ext;
    logic [31:0]   req_ext;
    logic          in_fire;
    logic          out_fire;
    logic          last_beat;
    logic [CW-1:0] c_nx;
    logic [LW-1:0] lvl_nx;

    assign c_ext   = 32'(con_master_counter);
    assign c_end   = c_ext + N;
    assign lvl_ext = 32'(con_buf_level);

    // Only the beat that crosses the message/parity boundary pops a partial count.
    assign req_ext = (state == MSG) ? ((c_end > RS_MES_LEN) ? RS_MES_LEN - c_ext : N) : 32'd0;

    assign last_beat   = (state != IDLE) && (c_end >= RS_COD_LEN);
    // alive keeps in_ready low until the first edge after reset release.
    assign in_ready    = alive && (lvl_ext <= N - 1) && !con_abort;
    assign out_valid   = (state != IDLE) && (lvl_ext >= req_ext);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign buf_request = RW'(req_ext);
    assign con_parity  = (state == PAR) || ((state == MSG) && (c_end > RS_MES_LEN));
    assign con_last    = last_beat;

    // A final beat still in MSG leaves exactly like a PAR final beat.
    assign state_nx = (state == IDLE) ? (con_enable ? MSG : IDLE) :
                      !out_fire       ? state :
                      last_beat       ? (con_enable ? MSG : IDLE) :
                      (c_end >= RS_MES_LEN) ? PAR : state;

    assign c_nx   = !out_fire ? con_master_counter :
                    (c_end >= RS_COD_LEN) ? '0 : CW'(c_end);
    assign lvl_nx = LW'(lvl_ext + (in_fire ? N : 0) - (out_fire ? req_ext : 32'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            con_master_counter <= '0;
            con_buf_level      <= '0;
            alive              <= 1'b0;
        end else if (con_abort) begin
            state              <= IDLE;
            con_master_counter <= '0;
            con_buf_level      <= '0;
            alive              <= 1'b1;
        end else begin
            state              <= state_nx;
            con_master_counter <= c_nx;
            con_buf_level      <= lvl_nx;
            alive              <= 1'b1;
        end
    end
endmodule

// File: tb/tb_enc_controller.sv
// tb_enc_controller: randomized and directed checks of enc_controller against a symbol-count model.
module tb_enc_controller;
    localparam int N   = 8;
    localparam int MES = 239;
    localparam int COD = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       con_enable = 1'b0;
    logic       con_abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] con_master_counter;
    logic [3:0] buf_request;
    logic [3:0] con_buf_level;
    logic       con_parity;
    logic       con_last;

    enc_controller #(.ENC_SYM_NUM(N), .RS_MES_LEN(MES), .RS_COD_LEN(COD)) dut (
        .clk(clk), .rst_n(rst_n), .con_enable(con_enable), .con_abort(con_abort),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .con_master_counter(con_master_counter), .buf_request(buf_request),
        .con_buf_level(con_buf_level), .con_parity(con_parity), .con_last(con_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: symbols already emitted in the codeword (pos), buffered symbols (lvl).
    bit m_alive, m_active;
    int m_pos, m_lvl;
    int e_req;
    bit e_ready, e_valid, e_parity, e_last;

    function void model_reset();
        m_alive = 0; m_active = 0; m_pos = 0; m_lvl = 0;
    endfunction

    function void model_eval();
        e_req    = (m_active && m_pos < MES) ? ((MES - m_pos < N) ? MES - m_pos : N) : 0;
        e_ready  = m_alive && m_lvl < N && !con_abort;
        e_valid  = m_active && m_lvl >= e_req;
        e_parity = m_active && m_pos + N > MES;
        e_last   = m_active && m_pos + N >= COD;
    endfunction

    task drive(input bit en, input bit ab, input bit iv, input bit ordy);
        @(negedge clk);
        con_enable = en; con_abort = ab; in_valid = iv; out_ready = ordy;
        #1;
        model_eval();
    endtask

    task tick();
        bit inf, outf;
        @(posedge clk);
        inf  = in_valid && e_ready;
        outf = e_valid && out_ready;
        if (con_abort) begin
            m_active = 0; m_pos = 0; m_lvl = 0;
        end else begin
            m_lvl = m_lvl + (inf ? N : 0) - (outf ? e_req : 0);
            if (outf) begin
                if (m_pos + N >= COD) begin
                    m_pos = 0;
                    m_active = con_enable;
                end else m_pos = m_pos + N;
            end else if (!m_active && con_enable) m_active = 1;
        end
        m_alive = 1;
        #1;
    endtask

    task run_to(input int target);
        for (int i = 0; i < 300 && !(m_active && m_pos == target); i++) begin
            drive(1, 0, 1, 1);
            n_checks++;
            if (con_master_counter !== 8'(m_pos)) begin
                n_fail++;
                $display("FAIL run_to_c: got %0d want %0d", con_master_counter, m_pos);
            end
            tick();
        end
        n_checks++;
        if (con_master_counter !== 8'(target)) begin
            n_fail++;
            $display("FAIL run_to_reach: got c=%0d want %0d", con_master_counter, target);
        end
    endtask

    task test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, con_parity, con_last, buf_request, con_buf_level, con_master_counter} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b par=%b last=%b req=%0d lvl=%0d c=%0d want all 0",
                     in_ready, out_valid, con_parity, con_last, buf_request, con_buf_level, con_master_counter);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        model_eval();
        tick();
        drive(0, 0, 0, 0);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task test_back_to_back();
        int k;
        k = 0;
        for (int i = 0; i < 400 && k < 96; i++) begin
            drive(1, 0, 1, 1);
            n_checks++;
            if ({in_ready, out_valid, buf_request, con_master_counter, con_last} !==
                {e_ready, e_valid, 4'(e_req), 8'(m_pos), e_last}) begin
                n_fail++;
                $display("FAIL b2b_model: got rdy=%b vld=%b req=%0d c=%0d last=%b want %b %b %0d %0d %b",
                         in_ready, out_valid, buf_request, con_master_counter, con_last,
                         e_ready, e_valid, e_req, m_pos, e_last);
            end
            if (e_valid) begin
                n_checks++;
                if ({con_master_counter, buf_request, con_last} !==
                    {8'((k % 32) * 8), 4'((k % 32) < 29 ? 8 : (k % 32) == 29 ? 7 : 0), 1'((k % 32) == 31)}) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got c=%0d req=%0d last=%b", k, con_master_counter, buf_request, con_last);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 96) begin
            n_fail++;
            $display("FAIL b2b_beats: got %0d want 96", k);
        end
    endtask

    task test_starvation();
        logic [7:0] c_hold;
        run_to(8);
        for (int i = 0; i < 4 && e_valid; i++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        c_hold = con_master_counter;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1);
            n_checks++;
            if (out_valid !== 1'b0 || con_master_counter !== c_hold) begin
                n_fail++;
                $display("FAIL starve_hold: got vld=%b c=%0d want 0 %0d", out_valid, con_master_counter, c_hold);
            end
            tick();
        end
        drive(1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || con_buf_level !== 4'(m_lvl)) begin
            n_fail++;
            $display("FAIL starve_resume: got vld=%b lvl=%0d want 1 %0d", out_valid, con_buf_level, m_lvl);
        end
        tick();
    endtask

    task test_backpressure();
        logic [3:0] lvl_hold;
        run_to(232);
        drive(1, 0, 1, 0);
        tick();
        lvl_hold = con_buf_level;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0);
            n_checks++;
            if ({con_master_counter, buf_request, con_buf_level, con_parity} !== {8'd232, 4'd7, lvl_hold, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_stable: got c=%0d req=%0d lvl=%0d par=%b want 232 7 %0d 1",
                         con_master_counter, buf_request, con_buf_level, con_parity, lvl_hold);
            end
            tick();
        end
        drive(1, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || con_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_mixed: got vld=%b par=%b want 1 1", out_valid, con_parity);
        end
        tick();
        n_checks++;
        if (con_master_counter !== 8'd240 || con_buf_level !== 4'(m_lvl)) begin
            n_fail++;
            $display("FAIL bp_after: got c=%0d lvl=%0d want 240 %0d", con_master_counter, con_buf_level, m_lvl);
        end
    endtask

    task test_simultaneous();
        int old_lvl, req, found;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            drive(1, 0, 1, 1);
            if (e_ready && e_valid) begin
                old_lvl = m_lvl;
                req = e_req;
                found = 1;
                n_checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sim_handshake: got rdy=%b vld=%b want 1 1", in_ready, out_valid);
                end
                tick();
                n_checks++;
                if (con_buf_level !== 4'(old_lvl + N - req)) begin
                    n_fail++;
                    $display("FAIL sim_level: got %0d want %0d", con_buf_level, old_lvl + N - req);
                end
            end else tick();
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL sim_found: got 0 want 1");
        end
    endtask

    task test_enable();
        run_to(240);
        for (int i = 0; i < 20 && m_active; i++) begin
            drive(0, 0, 1, 1);
            n_checks++;
            if (con_master_counter !== 8'(m_pos) || con_last !== e_last) begin
                n_fail++;
                $display("FAIL en_tail: got c=%0d last=%b want %0d %b", con_master_counter, con_last, m_pos, e_last);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1);
            n_checks++;
            if (out_valid !== 1'b0 || con_master_counter !== 8'd0 || buf_request !== 4'd0) begin
                n_fail++;
                $display("FAIL en_idle: got vld=%b c=%0d req=%0d want 0 0 0", out_valid, con_master_counter, buf_request);
            end
            tick();
        end
        drive(1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        n_checks++;
        if (con_master_counter !== 8'd0 || con_buf_level !== 4'(m_lvl) || out_valid !== e_valid || buf_request !== 4'd8) begin
            n_fail++;
            $display("FAIL en_restart: got c=%0d lvl=%0d vld=%b req=%0d want 0 %0d %b 8",
                     con_master_counter, con_buf_level, out_valid, buf_request, m_lvl, e_valid);
        end
        tick();
    endtask

    task test_abort();
        run_to(120);
        drive(1, 1, 1, 1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: got %b want 0", in_ready);
        end
        tick();
        drive(0, 0, 0, 0);
        n_checks++;
        if ({con_master_counter, con_buf_level, in_ready, out_valid} !== {8'd0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_clear: got c=%0d lvl=%0d rdy=%b vld=%b want 0 0 1 0",
                     con_master_counter, con_buf_level, in_ready, out_valid);
        end
        tick();
    endtask

    task test_reset_mid();
        run_to(120);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({con_master_counter, con_buf_level, in_ready, out_valid} !== {8'd0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got c=%0d lvl=%0d rdy=%b vld=%b want 0 0 0 0",
                     con_master_counter, con_buf_level, in_ready, out_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        con_enable = 1; con_abort = 0; in_valid = 0; out_ready = 0;
        #1;
        model_eval();
        tick();
        drive(1, 0, 0, 0);
        n_checks++;
        if (con_master_counter !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_restart: got c=%0d rdy=%b want 0 1", con_master_counter, in_ready);
        end
        tick();
    endtask

    task test_random();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            n_checks++;
            if ({in_ready, out_valid, buf_request, con_buf_level, con_master_counter, con_parity, con_last} !==
                {e_ready, e_valid, 4'(e_req), 4'(m_lvl), 8'(m_pos), e_parity, e_last}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got rdy=%b vld=%b req=%0d lvl=%0d c=%0d par=%b last=%b want %b %b %0d %0d %0d %b %b",
                         i, in_ready, out_valid, buf_request, con_buf_level, con_master_counter, con_parity, con_last,
                         e_ready, e_valid, e_req, m_lvl, m_pos, e_parity, e_last);
            end
            tick();
        end
        con_abort = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_starvation();
        test_backpressure();
        test_simultaneous();
        test_enable();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/enc_controller.md
ENC_CONTROLLER -- requirements
Module: enc_controller

Interface
REQ-001 The module SHALL use these constants from encoder.vh:
- ENC_SYM_NUM, default 8: symbols per beat.
- RS_MES_LEN, default 239: message symbols per codeword.
- RS_COD_LEN, default 255: codeword symbols.
- RS_COD_LEN SHALL exceed RS_MES_LEN.

REQ-002 The module SHALL have the following ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- con_enable  in  1  continue encoding; sampled at codeword boundaries.
- con_abort  in  1  synchronous clear to IDLE.
- in_valid  in  1  upstream beat of ENC_SYM_NUM message symbols offered.
- in_ready  out  1  controller accepts the upstream beat.
- out_valid  out  1  formatter output beat valid this cycle.
- out_ready  in  1  downstream accepts the output beat.
- con_master_counter  out  $clog2(RS_COD_LEN)  codeword index of the first symbol of the current beat.
- buf_request  out  $clog2(ENC_SYM_NUM+1)  message symbols the formatter pops this beat.
- con_buf_level  out  $clog2(2*ENC_SYM_NUM)  buffered symbol count, 0..2*ENC_SYM_NUM-1.
- con_parity  out  1  current beat contains parity symbols.
- con_last  out  1  current beat is the final beat of the codeword.

Function
REQ-003 The state machine SHALL have three states, encoded IDLE, MSG, PAR.
REQ-004 IDLE SHALL go to MSG when con_enable=1; out_valid=0 in IDLE.
REQ-005 Definitions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- c = con_master_counter.
- N = ENC_SYM_NUM.
REQ-006 in_ready SHALL equal (con_buf_level <= N-1) & ~con_abort, in every state including IDLE.
REQ-007 buf_request SHALL be computed combinationally:
- In MSG: min(N, RS_MES_LEN-c).
- In PAR and IDLE: 0.
REQ-008 out_valid SHALL be 1 in MSG/PAR when con_buf_level >= buf_request; otherwise 0.
REQ-009 con_buf_level next SHALL be level + (in_fire ? N : 0) - (out_fire ? buf_request : 0).
- in_fire and out_fire in the same cycle SHALL both apply.
- Overflow above 2N-1 or underflow below 0 SHALL be impossible by construction.
REQ-010 On out_fire, c SHALL advance by min(N, RS_COD_LEN-c).
- When c+N >= RS_COD_LEN, c SHALL wrap to 0.
REQ-011 MSG SHALL go to PAR on an out_fire where c+N >= RS_MES_LEN.
- con_parity SHALL be 1 on that beat when c+N > RS_MES_LEN (mixed message/parity beat).
- con_parity SHALL be 1 on all PAR beats.
REQ-012 con_last SHALL be 1 when state != IDLE and c+N >= RS_COD_LEN.
- If that beat is still in MSG (parity fits in the same beat), the last out_fire SHALL act as a PAR exit.
REQ-013 On the last-beat out_fire, the next state SHALL be MSG if con_enable=1, else IDLE.
- c SHALL be 0 in both cases.
- There SHALL be no bubble between back-to-back codewords.
REQ-014 con_enable SHALL have no effect mid-codeword.
REQ-015 con_abort=1 SHALL force, on the next edge:
- state=IDLE, c=0, con_buf_level=0.
- It SHALL override in_fire and out_fire in that cycle.
REQ-016 All outputs SHALL be driven from registers or from combinational decode of state, c and level only.
- No combinational path from out_ready to out_valid.
- No combinational path from in_valid to in_ready.
REQ-017 With defaults, each codeword SHALL take 32 beats:
- 29 full MSG beats (c=0..224).
- Mixed beat at c=232 (buf_request=7).
- PAR beats at c=240 and c=248; the c=248 beat has con_last=1.

Reset
REQ-018 While rst_n=0, the module SHALL hold:
- state=IDLE, c=0, con_buf_level=0.
- out_valid=0, in_ready=0, buf_request=0, con_parity=0, con_last=0.
REQ-019 After rst_n deasserts, in_ready SHALL go to 1 on the first cycle.
REQ-020 Reset asserted mid-codeword SHALL discard all progress; the next codeword SHALL start at c=0.

Verification
REQ-021 Back-to-back streaming, in_valid=out_ready=1, con_enable=1, 3 codewords:
- c follows 0,8,...,248,0,... with no gap.
- buf_request follows 8×29, then 7, then 0,0.
- con_last is 1 every 32nd beat.
REQ-022 Starvation, in_valid=0 after level=3 at c=8:
- out_valid=0, c holds at 8.
- A resumed in_fire raises level to 11 and out_valid to 1 the next cycle.
REQ-023 Backpressure, out_ready=0 for 5 cycles at c=232, level=7:
- c, level and buf_request (7) are stable throughout.
- The first out_ready=1 cycle fires a mixed beat with con_parity=1.
REQ-024 Simultaneous events, level=7, in_fire and out_fire (request 8) in the same cycle:
- Next level = 7.
- in_ready stays 1.
REQ-025 con_enable=0 at c=240:
- The beat at c=248 fires, then state=IDLE with c=0.
- Raising con_enable later restarts MSG at c=0 with level preserved.
REQ-026 Abort and reset mid-operation:
- con_abort at c=120, level=9 → next cycle IDLE, c=0, level=0, in_ready=1.
- rst_n pulse at c=120 gives the same state, asynchronously.
